// File: rtl/vec_mem_seq_if.sv
// rtl/vec_mem_seq_if.sv - 16-bit single-word data-memory port used by the vector memory sequencer
interface vec_mem_seq_if;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_gnt;
  logic [15:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_gnt, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_gnt, mem_rdata
  );
endinterface

// File: rtl/vec_mem_seq.sv
// rtl/vec_mem_seq.sv - splits a 256-bit VLD/VST into sixteen 16-bit memory accesses
// Optional VMEM_STRIDE_EN adds a signed 8-bit element stride (default: unit stride).
module vec_mem_seq #(
  parameter int LANES = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   is_store,
  input  logic [15:0]            base_addr,
  input  logic [LANES*16-1:0]    store_data,
`ifdef VMEM_STRIDE_EN
  input  logic [7:0]             stride,
`endif
  vec_mem_seq_if.master          mem,
  output logic                   busy,
  output logic                   done,
  output logic [LANES*16-1:0]    load_data
);
  localparam int IW = $clog2(LANES);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN, DONE} state_t;

  state_t                state, state_nxt;
  logic                  st_q;
  logic [15:0]           addr_q;
  logic [15:0]           step;
  logic [LANES*16-1:0]   sdata_q;
  logic [IW-1:0]         i_q;
  logic [IW-1:0]         r_q;
  logic                  rd_pend;
  logic                  accept;
  logic                  grant;
  logic                  last_issue;

  assign grant      = (state == REQ) && mem.mem_gnt;
  assign last_issue = (i_q == IW'(LANES - 1));
  assign mem.mem_addr = addr_q;

`ifdef VMEM_STRIDE_EN
  logic [15:0] step_q;
  assign step = step_q;
`else
  assign step = 16'd1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    accept        = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_wdata = 16'd0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        busy        = 1'b1;
        mem.mem_req = 1'b1;
        mem.mem_we  = st_q;
        if (st_q) mem.mem_wdata = sdata_q[{i_q, 4'b0000} +: 16];
        if (mem.mem_gnt && last_issue) state_nxt = st_q ? DONE : DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        // The final read returns one cycle after its grant.
        if (rd_pend) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = REQ;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q      <= 1'b0;
      addr_q    <= 16'd0;
      sdata_q   <= '0;
      i_q       <= '0;
      r_q       <= '0;
      rd_pend   <= 1'b0;
      load_data <= '0;
`ifdef VMEM_STRIDE_EN
      step_q    <= 16'd0;
`endif
    end else begin
      rd_pend <= grant && !st_q;
      if (accept) begin
        st_q    <= is_store;
        addr_q  <= base_addr;
        sdata_q <= store_data;
        i_q     <= '0;
        r_q     <= '0;
`ifdef VMEM_STRIDE_EN
        step_q  <= {{8{stride[7]}}, stride};
`endif
      end else if (grant) begin
        i_q    <= i_q + 1'b1;
        addr_q <= addr_q + step;
      end
      if (rd_pend) begin
        load_data[{r_q, 4'b0000} +: 16] <= mem.mem_rdata;
        r_q <= r_q + 1'b1;
      end
    end
  end
endmodule

// File: doc/vec_mem_seq.md
# vec_mem_seq

Vector memory sequencer for the 16-lane × 16-bit vector datapath. It takes the effective address the ALU computes for VLD/VST and the 256-bit operand from the register file. It then runs the transfer as sixteen single-word accesses on the 16-bit data-memory port. For loads it assembles the sixteen returned words back into a 256-bit vector for write-back.

## Interface
Parameters:
- `LANES`, 16: elements per vector. Fixed by the datapath; not to be overridden.

Ports (clock, reset, then others):
- `clk`  in  1  single clock; everything samples on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request a transfer; accepted only when `busy`=0.
- `is_store`  in  1  1 = VST, 0 = VLD; sampled with `start`.
- `base_addr`  in  16  effective address (ALU result[15:0]); sampled with `start`.
- `store_data`  in  256  vector to store; sampled with `start`.
- `stride`  in  8  signed element stride; present only with `VMEM_STRIDE_EN`.
- `mem_req`  out  1  memory access request.
- `mem_we`  out  1  1 = write, 0 = read; valid while `mem_req`=1.
- `mem_addr`  out  16  word address; valid while `mem_req`=1.
- `mem_wdata`  out  16  write data; valid while `mem_req`=1 and `mem_we`=1.
- `mem_gnt`  in  1  memory accepts the current request this cycle.
- `mem_rdata`  in  16  read data; valid exactly one cycle after a granted read.
- `busy`  out  1  transfer in progress.
- `done`  out  1  one-cycle pulse when the transfer is complete.
- `load_data`  out  256  assembled load vector; valid from `done` onward.

## Operation
- FSM states: IDLE, REQ, DRAIN, DONE.
- IDLE/DONE with `start`=1: latch `is_store`, `base_addr`, `store_data`; clear issue index `i` and receive index `r`; go to REQ.
- REQ:
  - `mem_req`=1, `mem_addr`=base+i·stride (mod 2^16, wrap silently), `mem_we`=`is_store`, `mem_wdata`=element i=bits[16i+15:16i].
  - On `mem_gnt`: i++.
  - Store: 16th grant → DONE.
  - Load: 16th grant → DRAIN.
  - `mem_gnt`=0: hold address and data stable; no advance.
- Load capture (REQ or DRAIN): the cycle after any granted read, `mem_rdata` → `load_data`[16r+15:16r]; r++.
- DRAIN: `mem_req`=0; capture element 15, then go to DONE.
- DONE: `done`=1 and `busy`=0 for one cycle. With no `start`, go to IDLE.
- `busy`=1 exactly in REQ and DRAIN; `start` while `busy`=1 is ignored.
- `load_data` changes only during a load; stores leave it untouched.
- Elements are ordered lane 0 first, i.e. lowest address.

## Timing
- Reset values: state=IDLE, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `busy`=0, `done`=0, `load_data`=0.
- Reset asserted mid-transfer aborts immediately; no further requests are issued.
- `mem_req`/`mem_addr`/`mem_we`/`mem_wdata` are decoded from registered state only; none depends combinationally on `mem_gnt`.
- Latency with `mem_gnt` held at 1, `start` high in cycle 0:
  - Requests occur in cycles 1–16.
  - Store: `done` in cycle 17.
  - Load: last data arrives in cycle 17; `done` in cycle 18.
- Each cycle of `mem_gnt`=0 during REQ adds one cycle of latency.
- A new `start` is accepted in the `done` cycle, giving back-to-back transfers.

## Configuration
- `VMEM_STRIDE_EN` defined:
  - `stride` port exists and is sign-extended to 16 bits.
  - Address for element i = base + i·stride, mod 2^16. Stride 0 accesses the same word 16 times.
- `VMEM_STRIDE_EN` undefined:
  - No `stride` port.
  - Stride is fixed at +1 (unit-stride, contiguous vectors).

## Test plan
- Store, base=0x0100, store_data lane i=0x1000+i, `mem_gnt`=1 → writes to 0x0100..0x010F with data 0x1000..0x100F in cycles 1–16; `done` in cycle 17.
- Load, base=0x0200, memory word A=A^0xFFFF → `load_data` lane i=0x0200+i ^ 0xFFFF; `done` in cycle 18; `busy` high in cycles 1–17.
- Load, base=0xFFF8 → addresses wrap after 0xFFFF to 0x0000..0x0007; lanes 8–15 hold words 0–7.
- `mem_gnt` low for 3 cycles at element 5 → `mem_addr`/`mem_wdata` held stable; `done` 3 cycles late; data correct.
- `start` during busy is ignored; `start` in the `done` cycle starts the next transfer with `mem_req` in the following cycle. `rst_n` low mid-load → all outputs reset asynchronously; no further requests.
- `VMEM_STRIDE_EN`: stride=-2, base=0x0040 → addresses 0x0040, 0x003E, …, 0x0022.
